// File: rtl/gpu_pkg.sv
// Shared types and encodings for the fetch/decode front end of func_unit.
package gpu_pkg;

    typedef enum logic [2:0] {
        OP_ADD  = 3'b000,
        OP_SUB  = 3'b001,
        OP_MUL  = 3'b010,
        OP_UDIV = 3'b011,
        OP_FADD = 3'b100,
        OP_FSUB = 3'b101
    } instr_type_t;

    localparam logic [6:0]  OPC_OP     = 7'b0110011;
    localparam logic [6:0]  OPC_OPFP   = 7'b1010011;
    localparam logic [6:0]  F7_BASE    = 7'b0000000;
    localparam logic [6:0]  F7_SUB     = 7'b0100000;
    localparam logic [6:0]  F7_MULDIV  = 7'b0000001;
    localparam logic [6:0]  F7_FSUB    = 7'b0000100;
    localparam logic [2:0]  F3_ADD     = 3'b000;
    localparam logic [2:0]  F3_DIVU    = 3'b101;
    localparam logic [31:0] ECALL_WORD = 32'h0000_0073;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_ISSUE,
        S_DONE,
        S_ERROR
    } fdu_state_t;

    typedef struct packed {
        logic        legal;
        logic        is_ecall;
        instr_type_t op;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [5:0]  shammt;
    } decoded_t;

endpackage

// File: rtl/rv_decoder.sv
// Combinational decode of one RISC-V word into func_unit operation fields.
module rv_decoder
    import gpu_pkg::*;
(
    input  logic [31:0] word,
    output decoded_t    dec
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;

    assign opcode = word[6:0];
    assign funct3 = word[14:12];
    assign funct7 = word[31:25];

    always_comb begin
        dec          = '0;
        dec.op       = OP_ADD;
        dec.rs1      = word[19:15];
        dec.rs2      = word[24:20];
        dec.rd       = word[11:7];
        dec.shammt   = word[25:20];
        dec.is_ecall = (word == ECALL_WORD);
        if (opcode == OPC_OP) begin
            if (funct3 == F3_ADD && funct7 == F7_BASE) begin
                dec.legal = 1'b1;
                dec.op    = OP_ADD;
            end else if (funct3 == F3_ADD && funct7 == F7_SUB) begin
                dec.legal = 1'b1;
                dec.op    = OP_SUB;
            end else if (funct3 == F3_ADD && funct7 == F7_MULDIV) begin
                dec.legal = 1'b1;
                dec.op    = OP_MUL;
            end else if (funct3 == F3_DIVU && funct7 == F7_MULDIV) begin
                dec.legal = 1'b1;
                dec.op    = OP_UDIV;
            end
        end else if (opcode == OPC_OPFP) begin
            // Rounding mode (funct3) is not used by func_unit.
            if (funct7 == F7_BASE) begin
                dec.legal = 1'b1;
                dec.op    = OP_FADD;
            end else if (funct7 == F7_FSUB) begin
                dec.legal = 1'b1;
                dec.op    = OP_FSUB;
            end
        end
    end

endmodule

// File: rtl/fetch_decode_unit.sv
// Fetches instruction words, decodes them and issues one operation at a time to func_unit.
module fetch_decode_unit
    import gpu_pkg::*;
#(
    parameter int unsigned MAX_INSTRS = 1024,
    parameter int unsigned CNT_W      = 11
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [31:0]      starting_pc,
    output logic             imem_req,
    output logic [31:0]      imem_addr,
    input  logic             imem_ack,
    input  logic [31:0]      imem_rdata,
    output logic             issue_valid,
    input  logic             issue_ready,
    output logic [2:0]       type_instruction,
    output logic [4:0]       regnum_1,
    output logic [4:0]       regnum_2,
    output logic [4:0]       dest_reg,
    output logic [5:0]       shammt,
    output logic             busy,
    output logic             done,
    output logic             illegal_instr,
    output logic [CNT_W-1:0] instr_count
);

    fdu_state_t       state;
    logic [31:0]      pc;
    logic [31:0]      pc_next;
    logic [31:0]      instr_word;
    logic [CNT_W-1:0] count_next;
    decoded_t         dec;

    assign pc_next    = pc + 32'd4;
    assign count_next = instr_count + CNT_W'(1);

    rv_decoder u_decoder (
        .word (instr_word),
        .dec  (dec)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state            <= S_IDLE;
            pc               <= '0;
            instr_word       <= '0;
            imem_req         <= 1'b0;
            imem_addr        <= '0;
            issue_valid      <= 1'b0;
            type_instruction <= '0;
            regnum_1         <= '0;
            regnum_2         <= '0;
            dest_reg         <= '0;
            shammt           <= '0;
            busy             <= 1'b0;
            done             <= 1'b0;
            illegal_instr    <= 1'b0;
            instr_count      <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    // A stray imem_ack here is a stale response and is dropped.
                    if (start) begin
                        pc            <= starting_pc & 32'hFFFF_FFFC;
                        imem_addr     <= starting_pc & 32'hFFFF_FFFC;
                        imem_req      <= 1'b1;
                        instr_count   <= '0;
                        illegal_instr <= 1'b0;
                        busy          <= 1'b1;
                        state         <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    if (imem_ack) begin
                        instr_word <= imem_rdata;
                        imem_req   <= 1'b0;
                        state      <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    if (dec.legal) begin
                        type_instruction <= 3'(dec.op);
                        regnum_1         <= dec.rs1;
                        regnum_2         <= dec.rs2;
                        dest_reg         <= dec.rd;
                        shammt           <= dec.shammt;
                        issue_valid      <= 1'b1;
                        state            <= S_ISSUE;
                    end else if (dec.is_ecall) begin
                        done  <= 1'b1;
                        state <= S_DONE;
                    end else begin
                        illegal_instr <= 1'b1;
                        done          <= 1'b1;
                        state         <= S_ERROR;
                    end
                end
                S_ISSUE: begin
                    if (issue_ready) begin
                        issue_valid <= 1'b0;
                        pc          <= pc_next;
                        instr_count <= count_next;
                        // Runaway guard wins over whatever the next word would be.
                        if (count_next == CNT_W'(MAX_INSTRS)) begin
                            done  <= 1'b1;
                            state <= S_DONE;
                        end else begin
                            imem_req  <= 1'b1;
                            imem_addr <= pc_next;
                            state     <= S_FETCH;
                        end
                    end
                end
                S_DONE, S_ERROR: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_decode_unit.sv
// Scoreboard bench for fetch_decode_unit: directed programs, expected ops queued at stimulus time.
module tb_fetch_decode_unit;

    localparam int unsigned MAX   = 4;
    localparam int unsigned CNT_W = 11;

    localparam logic [31:0] W_ADD   = 32'h0020_81B3;
    localparam logic [31:0] W_SUB   = 32'h4020_8133;
    localparam logic [31:0] W_MUL   = 32'h0220_81B3;
    localparam logic [31:0] W_DIVU  = 32'h0220_D1B3;
    localparam logic [31:0] W_FADD  = 32'h0020_81D3;
    localparam logic [31:0] W_FSUB  = 32'h0820_81D3;
    localparam logic [31:0] W_ECALL = 32'h0000_0073;
    localparam logic [31:0] W_BAD   = 32'hFFFF_FFFF;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [31:0]      starting_pc;
    logic             imem_req;
    logic [31:0]      imem_addr;
    logic             ack_mem = 1'b0;
    logic             ack_force = 1'b0;
    logic [31:0]      imem_rdata = '0;
    logic             issue_valid;
    logic             issue_ready;
    logic [2:0]       type_instruction;
    logic [4:0]       regnum_1;
    logic [4:0]       regnum_2;
    logic [4:0]       dest_reg;
    logic [5:0]       shammt;
    logic             busy;
    logic             done;
    logic             illegal_instr;
    logic [CNT_W-1:0] instr_count;

    typedef struct packed {
        logic [2:0] op;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
        logic [5:0] sh;
    } exp_t;

    exp_t        sb_q[$];
    exp_t        mon_e;
    logic [31:0] mem [logic [31:0]];

    int n_tests = 0, n_fail = 0;
    int cyc = 0, accepts = 0, done_cnt = 0, fetches = 0, req_cycles = 0;
    int ack_lat = 1, mem_wait = 0, last_accept_cyc = 0, last_done_cyc = 0;

    fetch_decode_unit #(.MAX_INSTRS(MAX), .CNT_W(CNT_W)) dut (
        .clk              (clk),
        .rst              (rst),
        .start            (start),
        .starting_pc      (starting_pc),
        .imem_req         (imem_req),
        .imem_addr        (imem_addr),
        .imem_ack         (ack_mem | ack_force),
        .imem_rdata       (imem_rdata),
        .issue_valid      (issue_valid),
        .issue_ready      (issue_ready),
        .type_instruction (type_instruction),
        .regnum_1         (regnum_1),
        .regnum_2         (regnum_2),
        .dest_reg         (dest_reg),
        .shammt           (shammt),
        .busy             (busy),
        .done             (done),
        .illegal_instr    (illegal_instr),
        .instr_count      (instr_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    function automatic exp_t mk(logic [2:0] op, logic [4:0] rs1, logic [4:0] rs2,
                                logic [4:0] rd, logic [5:0] sh);
        mk = {op, rs1, rs2, rd, sh};
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Instruction memory: acks on the ack_lat-th cycle of each request.
    always begin
        @(posedge clk);
        #1;
        if (imem_req && !rst) begin
            if (mem_wait == 0) fetches++;
            req_cycles++;
            mem_wait++;
            if (mem_wait >= ack_lat) begin
                ack_mem    = 1'b1;
                imem_rdata = mem.exists(imem_addr) ? mem[imem_addr] : 32'h0;
                mem_wait   = 0;
            end else begin
                ack_mem = 1'b0;
            end
        end else begin
            ack_mem  = 1'b0;
            mem_wait = 0;
        end
    end

    // Monitor: every accepted issue is popped from the scoreboard and compared.
    always @(negedge clk) begin
        if (!rst) begin
            if (issue_valid && issue_ready) begin
                accepts++;
                last_accept_cyc = cyc;
                if (sb_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL issue_unexpected: got op 0x%0h with nothing expected",
                             {type_instruction, regnum_1, regnum_2, dest_reg, shammt});
                end else begin
                    mon_e = sb_q.pop_front();
                    check("issue_op", {8'h0, type_instruction, regnum_1, regnum_2, dest_reg, shammt},
                          {8'h0, mon_e});
                end
            end
            if (done) begin
                done_cnt++;
                last_done_cyc = cyc;
            end
        end
    end

    task automatic do_start(logic [31:0] pc);
        starting_pc = pc;
        start       = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(string name, int budget);
        int d0 = done_cnt;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk);
            if (done_cnt != d0) begin
                #1;
                return;
            end
        end
        n_tests++;
        n_fail++;
        $display("FAIL %s: no done within %0d cycles", name, budget);
    endtask

    task automatic wait_issue_valid(string name, int budget);
        for (int i = 0; i < budget; i++) begin
            @(posedge clk);
            #1;
            if (issue_valid) return;
        end
        n_tests++;
        n_fail++;
        $display("FAIL %s: issue_valid not seen within %0d cycles", name, budget);
    endtask

    int a0, f0, r0;

    initial begin
        rst         = 1'b1;
        start       = 1'b0;
        starting_pc = '0;
        issue_ready = 1'b1;
        #2;
        check("reset_ctrl", {27'h0, imem_req, issue_valid, busy, done, illegal_instr}, 32'h0);
        check("reset_fields", {8'h0, type_instruction, regnum_1, regnum_2, dest_reg, shammt}, 32'h0);
        check("reset_addr", imem_addr, 32'h0);
        check("reset_count", 32'(instr_count), 32'h0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // 1: single ADD then ECALL
        mem[32'h100] = W_ADD;
        mem[32'h104] = W_ECALL;
        sb_q.push_back(mk(3'b000, 5'd1, 5'd2, 5'd3, 6'd2));
        a0 = accepts;
        do_start(32'h0000_0103);
        check("t1_req_after_start", 32'(imem_req), 32'h1);
        check("t1_addr_aligned", imem_addr, 32'h100);
        wait_done("t1_done", 50);
        check("t1_accepts", 32'(accepts - a0), 32'd1);
        check("t1_done_latency", 32'(last_done_cyc - last_accept_cyc), 32'd3);
        check("t1_count", 32'(instr_count), 32'd1);
        check("t1_idle", {30'h0, busy, done}, 32'h0);

        // 2: back-pressure on SUB
        mem[32'h180] = W_SUB;
        mem[32'h184] = W_ECALL;
        issue_ready = 1'b0;
        sb_q.push_back(mk(3'b001, 5'd1, 5'd2, 5'd2, 6'd2));
        a0 = accepts;
        do_start(32'h180);
        wait_issue_valid("t2_valid", 20);
        for (int i = 0; i < 5; i++) begin
            check("t2_hold_valid", 32'(issue_valid), 32'h1);
            check("t2_hold_fields", {8'h0, type_instruction, regnum_1, regnum_2, dest_reg, shammt},
                  {8'h0, mk(3'b001, 5'd1, 5'd2, 5'd2, 6'd2)});
            @(posedge clk);
            #1;
        end
        issue_ready = 1'b1;
        wait_done("t2_done", 50);
        check("t2_accepts", 32'(accepts - a0), 32'd1);

        // 3: mixed ops with 3-cycle fetch latency; the guard stops before the ECALL
        mem[32'h1000] = W_MUL;
        mem[32'h1004] = W_DIVU;
        mem[32'h1008] = W_FADD;
        mem[32'h100C] = W_FSUB;
        mem[32'h1010] = W_ECALL;
        ack_lat = 3;
        sb_q.push_back(mk(3'b010, 5'd1, 5'd2, 5'd3, 6'd34));
        sb_q.push_back(mk(3'b011, 5'd1, 5'd2, 5'd3, 6'd34));
        sb_q.push_back(mk(3'b100, 5'd1, 5'd2, 5'd3, 6'd2));
        sb_q.push_back(mk(3'b101, 5'd1, 5'd2, 5'd3, 6'd2));
        a0 = accepts;
        f0 = fetches;
        r0 = req_cycles;
        do_start(32'h1000);
        wait_done("t3_done", 200);
        check("t3_accepts", 32'(accepts - a0), 32'd4);
        check("t3_fetches", 32'(fetches - f0), 32'd4);
        check("t3_req_cycles", 32'(req_cycles - r0), 32'd12);
        check("t3_count", 32'(instr_count), 32'd4);
        ack_lat = 1;

        // 4: illegal second word
        mem[32'h200] = W_ADD;
        mem[32'h204] = W_BAD;
        sb_q.push_back(mk(3'b000, 5'd1, 5'd2, 5'd3, 6'd2));
        a0 = accepts;
        do_start(32'h200);
        wait_done("t4_done", 50);
        check("t4_accepts", 32'(accepts - a0), 32'd1);
        check("t4_illegal", 32'(illegal_instr), 32'h1);
        check("t4_count", 32'(instr_count), 32'd1);

        // 5: eight ADDs, guard at four
        for (int i = 0; i < 8; i++) mem[32'h300 + 32'(4 * i)] = W_ADD;
        for (int i = 0; i < 4; i++) sb_q.push_back(mk(3'b000, 5'd1, 5'd2, 5'd3, 6'd2));
        a0 = accepts;
        f0 = fetches;
        do_start(32'h300);
        check("t5_illegal_cleared", 32'(illegal_instr), 32'h0);
        wait_done("t5_done", 100);
        check("t5_accepts", 32'(accepts - a0), 32'd4);
        check("t5_count", 32'(instr_count), 32'd4);
        check("t5_illegal", 32'(illegal_instr), 32'h0);
        repeat (5) @(posedge clk);
        #1;
        check("t5_no_req", 32'(imem_req), 32'h0);
        check("t5_fetches", 32'(fetches - f0), 32'd4);

        // 6: reset while an operation is waiting in ISSUE
        mem[32'h400] = W_ADD;
        issue_ready = 1'b0;
        a0 = accepts;
        do_start(32'h400);
        wait_issue_valid("t6_valid", 20);
        #2;
        rst = 1'b1;
        #1;
        check("t6_rst_ctrl", {27'h0, imem_req, issue_valid, busy, done, illegal_instr}, 32'h0);
        check("t6_rst_fields", {8'h0, type_instruction, regnum_1, regnum_2, dest_reg, shammt}, 32'h0);
        check("t6_rst_addr", imem_addr, 32'h0);
        check("t6_rst_count", 32'(instr_count), 32'h0);
        @(posedge clk);
        #1;
        rst         = 1'b0;
        issue_ready = 1'b1;
        ack_force   = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        ack_force = 1'b0;
        check("t6_stale_ack", {30'h0, imem_req, busy}, 32'h0);
        check("t6_no_accept", 32'(accepts - a0), 32'd0);
        sb_q.push_back(mk(3'b000, 5'd1, 5'd2, 5'd3, 6'd2));
        a0 = accepts;
        do_start(32'h100);
        wait_done("t6_restart_done", 50);
        check("t6_restart_accepts", 32'(accepts - a0), 32'd1);
        check("t6_restart_count", 32'(instr_count), 32'd1);
        check("sb_drained", 32'(sb_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
